// File: rtl/tblock_dispatch_pkg.sv
// Shared types for the thread-block dispatcher: FSM state encoding and the
// launch descriptor latched at the kernel launch handshake.
package tblock_dispatch_pkg;

  localparam int unsigned DefPcWidth       = 32;
  localparam int unsigned DefAddressWidth  = 32;
  localparam int unsigned DefTblockIdxBits = 4;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_DONE,
    REPORT
  } state_e;

  typedef struct packed {
    logic [DefPcWidth-1:0]       pc;
    logic [DefAddressWidth-1:0]  dp_addr;
    logic [DefTblockIdxBits:0]   num_tblocks;
  } launch_desc_t;

endpackage

// File: rtl/tblock_dispatcher_id_pool.sv
// In-flight block id bitmap. Offers the lowest free id from registered state
// only, so an id released this cycle becomes allocatable on the next one.
module tblock_id_pool #(
  parameter int unsigned TblockIdBits = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    set_i,
  input  logic [TblockIdBits-1:0] set_id_i,
  input  logic                    clr_i,
  input  logic [TblockIdBits-1:0] clr_id_i,
  output logic [TblockIdBits-1:0] free_id_o,
  output logic                    any_free_o
);

  localparam int unsigned NumIds = 2 ** TblockIdBits;

  logic [NumIds-1:0] in_flight_q, in_flight_d;

  always_comb begin
    free_id_o  = '0;
    any_free_o = 1'b0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (!any_free_o && !in_flight_q[i]) begin
        free_id_o  = TblockIdBits'(i);
        any_free_o = 1'b1;
      end
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (set_i) in_flight_d[set_id_i] = 1'b1;
    if (clr_i) in_flight_d[clr_id_i] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) in_flight_q <= '0;
    else         in_flight_q <= in_flight_d;
  end

  a_done_id_in_flight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    clr_i |-> in_flight_q[clr_id_i]);

endmodule

// File: rtl/tblock_dispatcher.sv
// Kernel launch to per-block warp allocation dispatcher for one compute unit.
// Define TBLOCK_DISPATCHER_PERF_EN to build the launch-to-done cycle counter.
module tblock_dispatcher
  import tblock_dispatch_pkg::*;
#(
  parameter int unsigned PcWidth       = DefPcWidth,
  parameter int unsigned AddressWidth  = DefAddressWidth,
  parameter int unsigned TblockIdxBits = DefTblockIdxBits,
  parameter int unsigned TblockIdBits  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     launch_valid_i,
  output logic                     launch_ready_o,
  input  logic [PcWidth-1:0]       launch_pc_i,
  input  logic [AddressWidth-1:0]  launch_dp_addr_i,
  input  logic [TblockIdxBits:0]   launch_num_tblocks_i,
  output logic                     kernel_done_valid_o,
  input  logic                     kernel_done_ready_i,
  output logic [31:0]              kernel_cycles_o,
  input  logic                     warp_free_i,
  output logic                     allocate_warp_o,
  output logic [PcWidth-1:0]       allocate_pc_o,
  output logic [AddressWidth-1:0]  allocate_dp_addr_o,
  output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
  output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
  input  logic                     tblock_done_i,
  input  logic [TblockIdBits-1:0]  tblock_done_id_i,
  output logic                     tblock_done_ready_o
);

  localparam int unsigned CntW = TblockIdxBits + 1;

  // The packed descriptor in the package fixes these widths.
  if (PcWidth != DefPcWidth || AddressWidth != DefAddressWidth ||
      TblockIdxBits != DefTblockIdxBits) begin : g_width_check
    $error("tblock_dispatcher: descriptor widths do not match tblock_dispatch_pkg");
  end

  state_e                   state_q, state_d;
  launch_desc_t             desc_q, desc_d;
  logic [TblockIdxBits-1:0] next_idx_q, next_idx_d;
  logic [CntW-1:0]          dispatched_q, dispatched_d;
  logic [CntW-1:0]          completed_q, completed_d;
  logic [TblockIdBits-1:0]  free_id;
  logic                     any_free;
  logic                     launch_fire;

  assign launch_fire           = launch_valid_i && launch_ready_o;
  assign allocate_pc_o         = desc_q.pc;
  assign allocate_dp_addr_o    = desc_q.dp_addr;
  assign allocate_tblock_idx_o = next_idx_q;
  assign allocate_tblock_id_o  = free_id;
  assign tblock_done_ready_o   = 1'b1;

  tblock_id_pool #(
    .TblockIdBits(TblockIdBits)
  ) u_id_pool (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (allocate_warp_o),
    .set_id_i   (free_id),
    .clr_i      (tblock_done_i),
    .clr_id_i   (tblock_done_id_i),
    .free_id_o  (free_id),
    .any_free_o (any_free)
  );

  always_comb begin
    state_d             = state_q;
    desc_d              = desc_q;
    next_idx_d          = next_idx_q;
    dispatched_d        = dispatched_q;
    completed_d         = completed_q + CntW'(tblock_done_i);
    launch_ready_o      = 1'b0;
    kernel_done_valid_o = 1'b0;
    allocate_warp_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        launch_ready_o = 1'b1;
        if (launch_valid_i) begin
          desc_d.pc          = launch_pc_i;
          desc_d.dp_addr     = launch_dp_addr_i;
          desc_d.num_tblocks = launch_num_tblocks_i;
          next_idx_d         = '0;
          dispatched_d       = '0;
          completed_d        = '0;
          state_d            = (launch_num_tblocks_i == '0) ? REPORT : DISPATCH;
        end
      end
      DISPATCH: begin
        allocate_warp_o = warp_free_i && any_free;
        if (allocate_warp_o) begin
          next_idx_d   = next_idx_q + TblockIdxBits'(1);
          dispatched_d = dispatched_q + CntW'(1);
          if (dispatched_d == desc_q.num_tblocks) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (completed_d == desc_q.num_tblocks) state_d = REPORT;
      end
      REPORT: begin
        kernel_done_valid_o = 1'b1;
        if (kernel_done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      desc_q       <= '0;
      next_idx_q   <= '0;
      dispatched_q <= '0;
      completed_q  <= '0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      next_idx_q   <= next_idx_d;
      dispatched_q <= dispatched_d;
      completed_q  <= completed_d;
    end
  end

`ifdef TBLOCK_DISPATCHER_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (launch_fire)                              cycles_d = '0;
    else if (state_q != IDLE && cycles_q != '1)   cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycles_q <= '0;
    else         cycles_q <= cycles_d;
  end

  assign kernel_cycles_o = cycles_q;
`else
  assign kernel_cycles_o = '0;
`endif

  a_done_not_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tblock_done_i |-> state_q != IDLE);
  a_launch_num_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    launch_fire |-> launch_num_tblocks_i <= CntW'(2 ** TblockIdxBits));
  a_alloc_needs_warp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(allocate_warp_o && !warp_free_i));

endmodule

// File: tb/tb_tblock_dispatcher.sv
// Directed scoreboard bench for tblock_dispatcher with a 4-entry id pool.
module tb_tblock_dispatcher;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        launch_valid_i;
  logic        launch_ready_o;
  logic [31:0] launch_pc_i;
  logic [31:0] launch_dp_addr_i;
  logic [4:0]  launch_num_tblocks_i;
  logic        kernel_done_valid_o;
  logic        kernel_done_ready_i;
  logic [31:0] kernel_cycles_o;
  logic        warp_free_i;
  logic        allocate_warp_o;
  logic [31:0] allocate_pc_o;
  logic [31:0] allocate_dp_addr_o;
  logic [3:0]  allocate_tblock_idx_o;
  logic [1:0]  allocate_tblock_id_o;
  logic        tblock_done_i;
  logic [1:0]  tblock_done_id_i;
  logic        tblock_done_ready_o;

  typedef struct {
    int unsigned idx;
    int unsigned id;
  } exp_alloc_t;

  exp_alloc_t  sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  logic [31:0] cur_pc = '0;
  logic [31:0] cur_dp = '0;

  tblock_dispatcher #(
    .PcWidth      (32),
    .AddressWidth (32),
    .TblockIdxBits(4),
    .TblockIdBits (2)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .launch_valid_i       (launch_valid_i),
    .launch_ready_o       (launch_ready_o),
    .launch_pc_i          (launch_pc_i),
    .launch_dp_addr_i     (launch_dp_addr_i),
    .launch_num_tblocks_i (launch_num_tblocks_i),
    .kernel_done_valid_o  (kernel_done_valid_o),
    .kernel_done_ready_i  (kernel_done_ready_i),
    .kernel_cycles_o      (kernel_cycles_o),
    .warp_free_i          (warp_free_i),
    .allocate_warp_o      (allocate_warp_o),
    .allocate_pc_o        (allocate_pc_o),
    .allocate_dp_addr_o   (allocate_dp_addr_o),
    .allocate_tblock_idx_o(allocate_tblock_idx_o),
    .allocate_tblock_id_o (allocate_tblock_id_o),
    .tblock_done_i        (tblock_done_i),
    .tblock_done_id_i     (tblock_done_id_i),
    .tblock_done_ready_o  (tblock_done_ready_o)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cycles();
`ifdef TBLOCK_DISPATCHER_PERF_EN
    return 64'(cyc - t0);
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int unsigned idx, input int unsigned id);
    exp_alloc_t e;
    e.idx = idx;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [4:0] num, input logic [31:0] pc, input logic [31:0] dp);
    launch_valid_i       = 1'b1;
    launch_num_tblocks_i = num;
    launch_pc_i          = pc;
    launch_dp_addr_i     = dp;
    cur_pc               = pc;
    cur_dp               = dp;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk_i);
    chk({tag, "_launch_ready"}, launch_ready_o, 1);
    chk({tag, "_kdone_valid"}, kernel_done_valid_o, 0);
    chk({tag, "_alloc"}, allocate_warp_o, 0);
    chk({tag, "_done_ready"}, tblock_done_ready_o, 1);
    chk({tag, "_cycles"}, kernel_cycles_o, 0);
  endtask

  // Every allocation fire is matched against the next expected (idx, id).
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && allocate_warp_o === 1'b1) begin
      exp_alloc_t e;
      chk("alloc_needs_warp_free", warp_free_i, 1);
      chk("alloc_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("alloc_idx", allocate_tblock_idx_o, e.idx);
        chk("alloc_id", allocate_tblock_id_o, e.id);
        chk("alloc_pc", allocate_pc_o, cur_pc);
        chk("alloc_dp", allocate_dp_addr_o, cur_dp);
      end
    end
  end

  initial begin
    rst_ni               = 1'b0;
    launch_valid_i       = 1'b0;
    launch_pc_i          = '0;
    launch_dp_addr_i     = '0;
    launch_num_tblocks_i = '0;
    kernel_done_ready_i  = 1'b0;
    warp_free_i          = 1'b0;
    tblock_done_i        = 1'b0;
    tblock_done_id_i     = '0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    tick();
    rst_ni = 1'b1;

    // Three blocks back to back, out-of-order completion, held report.
    warp_free_i = 1'b1;
    launch(5'd3, 32'h100, 32'h8000);
    push(0, 0); push(1, 1); push(2, 2);
    @(negedge clk_i);
    chk("t1_launch_ready", launch_ready_o, 1);
    tick();
    launch_valid_i = 1'b0;
    t0 = cyc;
    repeat (3) begin
      @(negedge clk_i);
      chk("t1_back_to_back", allocate_warp_o, 1);
      tick();
    end
    @(negedge clk_i);
    chk("t1_wait_no_alloc", allocate_warp_o, 0);
    chk("t1_launch_busy_wait", launch_ready_o, 0);
    tblock_done_i = 1'b1; tblock_done_id_i = 2'd1;
    tick();
    tblock_done_id_i = 2'd0;
    tick();
    @(negedge clk_i);
    chk("t1_not_done_early", kernel_done_valid_o, 0);
    tblock_done_id_i = 2'd2;
    tick();
    tblock_done_i = 1'b0;
    @(negedge clk_i);
    chk("t1_done_valid", kernel_done_valid_o, 1);
    chk("t1_launch_busy", launch_ready_o, 0);
    chk("t1_cycles", kernel_cycles_o, exp_cycles());
    tick();
    @(negedge clk_i);
    chk("t1_done_hold1", kernel_done_valid_o, 1);
    tick();
    kernel_done_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t1_done_hold2", kernel_done_valid_o, 1);
    tick();
    kernel_done_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t1_back_idle_ready", launch_ready_o, 1);
    chk("t1_back_idle_valid", kernel_done_valid_o, 0);

    // Empty kernel goes straight to report.
    launch(5'd0, 32'h180, 32'h8800);
    tick();
    launch_valid_i = 1'b0;
    t0 = cyc;
    @(negedge clk_i);
    chk("t2_done_valid", kernel_done_valid_o, 1);
    chk("t2_launch_busy", launch_ready_o, 0);
    chk("t2_no_alloc", allocate_warp_o, 0);
    chk("t2_cycles0", kernel_cycles_o, exp_cycles());
    tick();
    kernel_done_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t2_done_hold", kernel_done_valid_o, 1);
    chk("t2_cycles1", kernel_cycles_o, exp_cycles());
    tick();
    kernel_done_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t2_idle", launch_ready_o, 1);

    // Pool exhaustion with six blocks and four ids, then reuse of id 2.
    launch(5'd6, 32'h200, 32'h9000);
    push(0, 0); push(1, 1); push(2, 2); push(3, 3);
    tick();
    launch_valid_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      chk("t3_fill", allocate_warp_o, 1);
      tick();
    end
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_stall", allocate_warp_o, 0);
      tick();
    end
    tblock_done_i = 1'b1; tblock_done_id_i = 2'd2;
    @(negedge clk_i);
    chk("t3_no_same_cycle_reuse", allocate_warp_o, 0);
    push(4, 2);
    tick();
    tblock_done_i = 1'b0;
    @(negedge clk_i);
    chk("t3_reuse", allocate_warp_o, 1);
    tick();
    @(negedge clk_i);
    chk("t3_stall_again", allocate_warp_o, 0);
    chk("t3_sb_empty", sb.size(), 0);
    rst_ni = 1'b0;
    chk_reset_outputs("t3_rst");
    tick();
    rst_ni = 1'b1;

    // warp_free gating, then reset after two of five blocks.
    launch(5'd5, 32'h300, 32'hA000);
    push(0, 0);
    tick();
    launch_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_free1", allocate_warp_o, 1);
    tick();
    warp_free_i = 1'b0;
    @(negedge clk_i);
    chk("t4_free0", allocate_warp_o, 0);
    tick();
    warp_free_i = 1'b1;
    push(1, 1);
    @(negedge clk_i);
    chk("t4_free1_again", allocate_warp_o, 1);
    tick();
    rst_ni = 1'b0;
    chk_reset_outputs("t4_rst");
    tick();
    rst_ni = 1'b1;

    // Fresh launch, same-cycle allocate id 3 and complete id 0.
    launch(5'd5, 32'h400, 32'hB000);
    push(0, 0); push(1, 1); push(2, 2); push(3, 3);
    tick();
    launch_valid_i = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        tblock_done_i = 1'b1; tblock_done_id_i = 2'd0;
      end
      @(negedge clk_i);
      chk("t5_alloc", allocate_warp_o, 1);
      tick();
    end
    tblock_done_i = 1'b0;
    push(4, 0);
    @(negedge clk_i);
    chk("t5_id0_reuse", allocate_warp_o, 1);
    tick();
    @(negedge clk_i);
    chk("t5_wait_no_alloc", allocate_warp_o, 0);
    tblock_done_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tblock_done_id_i = 2'((i + 1) % 4);
      tick();
    end
    tblock_done_i = 1'b0;
    @(negedge clk_i);
    chk("t5_done_valid", kernel_done_valid_o, 1);
    chk("t5_cycles", kernel_cycles_o, exp_cycles());
    kernel_done_ready_i = 1'b1;
    tick();
    kernel_done_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t5_idle", launch_ready_o, 1);
    chk("t5_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
